// File: rtl/t1emu_run_pkg.sv
// Shared types for the t1emu run controller.
package t1emu_run_pkg;

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    EXIT_NONE    = 2'd0,
    EXIT_QUIT    = 2'd1,
    EXIT_TIMEOUT = 2'd2
  } exit_code_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t1emu_run_wdog.sv
// Retirement watchdog: counts enabled cycles since the last clear and flags the last one.
module t1emu_run_wdog
  import t1emu_run_pkg::*;
#(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = cnt_width(CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // Clear has priority; counting stops at the expiry value so it never wraps.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != CntLast)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (cnt_q == CntLast);

endmodule

// File: rtl/t1emu_run_ctrl.sv
// Run controller: stretches DUT reset, counts run cycles, watches for hangs,
// gates trace capture and sequences drain/finish at end of run.
module t1emu_run_ctrl
  import t1emu_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 8,
  parameter int unsigned WATCHDOG_CYCLES = 100000,
  parameter int unsigned DRAIN_CYCLES    = 16,
  parameter int unsigned CNT_W           = 64
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             quit_req_i,
  input  logic             retire_valid_i,
  input  logic [CNT_W-1:0] trace_start_i,
  input  logic [CNT_W-1:0] trace_stop_i,
  output logic             dut_reset_o,
  output logic             trace_en_o,
  output logic             finish_o,
  output logic [1:0]       exit_code_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [1:0]       run_state_o
);

  localparam int unsigned HoldW  = cnt_width(RESET_CYCLES);
  localparam int unsigned DrainW = cnt_width(DRAIN_CYCLES);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(RESET_CYCLES - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

  run_state_e        state_q;
  exit_code_e        exit_q;
  logic              dut_reset_q;
  logic              finish_q;
  logic [HoldW-1:0]  hold_q;
  logic [DrainW-1:0] drain_q;
  logic [CNT_W-1:0]  cycle_q;
  logic              wd_expire;

  t1emu_run_wdog #(
    .CYCLES(WATCHDOG_CYCLES)
  ) u_wdog (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear_i  (retire_valid_i),
    .enable_i (state_q == StRun),
    .expire_o (wd_expire)
  );

  // Run-phase FSM with all its registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StHold;
      exit_q      <= EXIT_NONE;
      dut_reset_q <= 1'b1;
      finish_q    <= 1'b0;
      hold_q      <= '0;
      drain_q     <= '0;
      cycle_q     <= '0;
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        StHold: begin
          if (hold_q == HoldLast) begin
            state_q     <= StRun;
            dut_reset_q <= 1'b0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        StRun: begin
          if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
          // Quit beats a simultaneous timeout; a retire in the expiry cycle cancels it.
          if (quit_req_i) begin
            state_q <= StDrain;
            exit_q  <= EXIT_QUIT;
            drain_q <= '0;
          end else if (wd_expire && !retire_valid_i) begin
            state_q <= StDrain;
            exit_q  <= EXIT_TIMEOUT;
            drain_q <= '0;
          end
        end
        StDrain: begin
          if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
          if (drain_q == DrainLast) begin
            state_q  <= StDone;
            finish_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StDone: begin
          // Terminal until reset.
        end
      endcase
    end
  end

  // Trace window decode; an empty or inverted window never enables.
  always_comb begin
    trace_en_o = ((state_q == StRun) || (state_q == StDrain)) &&
                 (cycle_q >= trace_start_i) && (cycle_q < trace_stop_i);
  end

  assign dut_reset_o   = dut_reset_q;
  assign finish_o      = finish_q;
  assign exit_code_o   = exit_q;
  assign cycle_count_o = cycle_q;
  assign run_state_o   = state_q;

endmodule

// File: tb/tb_t1emu_run_ctrl.sv
// Directed bench for t1emu_run_ctrl.
module tb_t1emu_run_ctrl;

  localparam int unsigned CntW = 64;

  logic            clock_i;
  logic            reset_i;
  logic            quit_req_i;
  logic            retire_valid_i;
  logic [CntW-1:0] trace_start_i;
  logic [CntW-1:0] trace_stop_i;
  logic            dut_reset_o;
  logic            trace_en_o;
  logic            finish_o;
  logic [1:0]      exit_code_o;
  logic [CntW-1:0] cycle_count_o;
  logic [1:0]      run_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  t1emu_run_ctrl #(
    .RESET_CYCLES    (8),
    .WATCHDOG_CYCLES (50),
    .DRAIN_CYCLES    (16),
    .CNT_W           (CntW)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .quit_req_i     (quit_req_i),
    .retire_valid_i (retire_valid_i),
    .trace_start_i  (trace_start_i),
    .trace_stop_i   (trace_stop_i),
    .dut_reset_o    (dut_reset_o),
    .trace_en_o     (trace_en_o),
    .finish_o       (finish_o),
    .exit_code_o    (exit_code_o),
    .cycle_count_o  (cycle_count_o),
    .run_state_o    (run_state_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  // Reset pulse followed by the 8-edge hold; returns in the first RUN cycle.
  task automatic restart();
    @(negedge clock_i);
    reset_i        = 1'b1;
    quit_req_i     = 1'b0;
    retire_valid_i = 1'b0;
    tick();
    reset_i = 1'b0;
    repeat (8) tick();
    chk("restart_state", run_state_o, 1);
    chk("restart_cyc", cycle_count_o, 0);
  endtask

  initial begin
    reset_i        = 1'b1;
    quit_req_i     = 1'b0;
    retire_valid_i = 1'b0;
    trace_start_i  = 64'd10;
    trace_stop_i   = 64'd20;
    tick();
    tick();

    // Reset values.
    chk("rst_dut_reset", dut_reset_o, 1);
    chk("rst_state", run_state_o, 0);
    chk("rst_exit", exit_code_o, 0);
    chk("rst_finish", finish_o, 0);
    chk("rst_cycle", cycle_count_o, 0);
    chk("rst_trace", trace_en_o, 0);

    // Reset stretch: high through edge 7, low from edge 8.
    reset_i = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("hold_dut_reset", dut_reset_o, 1);
      chk("hold_state", run_state_o, 0);
    end
    tick();
    chk("run_dut_reset", dut_reset_o, 0);
    chk("run_state", run_state_o, 1);

    // Count and trace window 10..19 with watchdog kept quiet.
    retire_valid_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      chk("run_cycle", cycle_count_o, c);
      chk("trace_win", trace_en_o, (c >= 10 && c < 20));
      tick();
    end
    chk("quit_cycle", cycle_count_o, 100);

    // Quit at cycle 100: 16 drain cycles, finish with cycle_count 117.
    quit_req_i = 1'b1;
    tick();
    quit_req_i = 1'b0;
    chk("drain_state", run_state_o, 2);
    chk("drain_exit", exit_code_o, 1);
    chk("drain_cycle", cycle_count_o, 101);
    for (int d = 1; d <= 15; d++) begin
      tick();
      chk("drain_hold", run_state_o, 2);
      chk("drain_nofinish", finish_o, 0);
    end
    tick();
    chk("done_state", run_state_o, 3);
    chk("done_finish", finish_o, 1);
    chk("done_cycle", cycle_count_o, 117);
    chk("done_trace", trace_en_o, 0);
    tick();
    chk("finish_pulse", finish_o, 0);
    chk("done_frozen", cycle_count_o, 117);
    quit_req_i = 1'b1;
    tick();
    quit_req_i = 1'b0;
    chk("done_quit_state", run_state_o, 3);
    chk("done_quit_exit", exit_code_o, 1);
    chk("done_quit_finish", finish_o, 0);

    // Watchdog timeout with no retire.
    restart();
    repeat (49) tick();
    chk("wd_pre_state", run_state_o, 1);
    chk("wd_pre_cycle", cycle_count_o, 49);
    tick();
    chk("wd_state", run_state_o, 2);
    chk("wd_exit", exit_code_o, 2);
    chk("wd_cycle", cycle_count_o, 50);

    // Reset mid-drain, asynchronously between edges.
    repeat (3) tick();
    #2 reset_i = 1'b1;
    #1;
    chk("mid_dut_reset", dut_reset_o, 1);
    chk("mid_state", run_state_o, 0);
    chk("mid_exit", exit_code_o, 0);
    chk("mid_cycle", cycle_count_o, 0);
    chk("mid_finish", finish_o, 0);
    restart();
    quit_req_i = 1'b1;
    tick();
    quit_req_i = 1'b0;
    chk("rerun_drain", run_state_o, 2);
    repeat (15) tick();
    chk("rerun_nofinish", finish_o, 0);
    tick();
    chk("rerun_done", run_state_o, 3);
    chk("rerun_finish", finish_o, 1);
    chk("rerun_cycle", cycle_count_o, 17);

    // Retire every 40 cycles never times out.
    restart();
    for (int c = 0; c < 200; c++) begin
      retire_valid_i = ((c % 40) == 39);
      tick();
    end
    retire_valid_i = 1'b0;
    chk("retire40_state", run_state_o, 1);
    chk("retire40_cycle", cycle_count_o, 200);

    // Retire in the expiry cycle cancels the timeout; then quit collides with expiry.
    restart();
    repeat (49) tick();
    retire_valid_i = 1'b1;
    tick();
    retire_valid_i = 1'b0;
    chk("rv_expiry_state", run_state_o, 1);
    chk("rv_expiry_cycle", cycle_count_o, 50);
    repeat (49) tick();
    chk("q_expiry_pre", run_state_o, 1);
    quit_req_i = 1'b1;
    tick();
    quit_req_i = 1'b0;
    chk("q_expiry_state", run_state_o, 2);
    chk("q_expiry_exit", exit_code_o, 1);

    // Inverted trace window stays closed.
    trace_start_i = 64'd20;
    trace_stop_i  = 64'd10;
    restart();
    retire_valid_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      chk("trace_inv", trace_en_o, 0);
      tick();
    end
    retire_valid_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
